// File: rtl/video_in_pkg.sv
// Shared frame/tile geometry, pixel type and clip records for the tile fill path.
// clip_axis() clips one signed tile origin against one frame dimension.
package video_in_pkg;

   localparam int IMG_W   = 640;
   localparam int IMG_H   = 480;
   localparam int TILE    = 32;
   localparam int PIX_W   = 8;
   localparam int TILE_LG = $clog2(TILE);
   localparam int POS_W   = $clog2(IMG_W);
   localparam int FS_AW   = $clog2(IMG_W * IMG_H);
   localparam int CA_W    = 2 * TILE_LG;

   typedef logic [PIX_W-1:0] pix_t;

   typedef enum logic [2:0] {
      IDLE,
      CLIP,
      SCAN,
      WAIT,
      DONE
   } fill_state_e;

   typedef struct packed {
      logic [POS_W-1:0]   pos;
      logic [TILE_LG:0]   len;
      logic [TILE_LG-1:0] dec;
      logic               vis;
   } axis_clip_t;

   typedef struct packed {
      logic [POS_W-1:0]   x_img;
      logic [POS_W-1:0]   y_img;
      logic [TILE_LG:0]   w_img;
      logic [TILE_LG:0]   h_img;
      logic [TILE_LG-1:0] dec_w;
      logic [TILE_LG-1:0] dec_h;
      logic               in_img;
   } clip_t;

   // len/dec/pos are only meaningful when vis is set.
   function automatic axis_clip_t clip_axis(input logic signed [31:0] org, input int lim);
      axis_clip_t a;
      a     = '0;
      a.vis = !((org > lim - 1) || (org + TILE - 1 < 0));
      if (org < 0) begin
         a.len = (TILE_LG+1)'(TILE + org);
         a.dec = TILE_LG'(-org);
      end else if (org > lim - TILE) begin
         a.len = (TILE_LG+1)'(lim - org);
         a.pos = POS_W'(org);
      end else begin
         a.len = (TILE_LG+1)'(TILE);
         a.pos = POS_W'(org);
      end
      return a;
   endfunction

endpackage

// File: rtl/tile_clip.sv
// Combinational clip of a signed tile origin against the frame.
// Each axis clips independently; the tile is in-image only if both axes overlap.
module tile_clip
   import video_in_pkg::*;
(
   input  logic signed [31:0] org_x,
   input  logic signed [31:0] org_y,
   output clip_t              clip
);

   logic signed [31:0] org_a  [2];
   axis_clip_t         axis_a [2];

   assign org_a[0] = org_x;
   assign org_a[1] = org_y;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_axis
         localparam int LIM = (gi == 0) ? IMG_W : IMG_H;
         assign axis_a[gi] = clip_axis(org_a[gi], LIM);
      end
   endgenerate

   always_comb begin
      clip        = '0;
      clip.x_img  = axis_a[0].pos;
      clip.y_img  = axis_a[1].pos;
      clip.w_img  = axis_a[0].len;
      clip.h_img  = axis_a[1].len;
      clip.dec_w  = axis_a[0].dec;
      clip.dec_h  = axis_a[1].dec;
      clip.in_img = axis_a[0].vis & axis_a[1].vis;
   end

endmodule

// File: rtl/cache_tile_fill.sv
// Fills one TILE x TILE cache tile from the frame store in raster order,
// reading in-image pixels and writing BG_PIX for pixels outside the frame.
module cache_tile_fill
   import video_in_pkg::*;
#(
   parameter pix_t BG_PIX = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic signed [31:0]  tile_x,
   input  logic signed [31:0]  tile_y,
   output logic                busy,
   output logic                done,
   output logic                rd_req,
   output logic [FS_AW-1:0]    rd_addr,
   input  logic                rd_ack,
   input  logic [PIX_W-1:0]    rd_data,
   output logic                cw_en,
   output logic [CA_W-1:0]     cw_addr,
   output logic [PIX_W-1:0]    cw_data
);

   fill_state_e        state_reg, state_next;
   logic signed [31:0] org_x_reg, org_x_next;
   logic signed [31:0] org_y_reg, org_y_next;
   clip_t              clip_reg, clip_next;
   logic [TILE_LG-1:0] row_reg, row_next;
   logic [TILE_LG-1:0] col_reg, col_next;
   logic               busy_reg, busy_next;
   logic               done_reg, done_next;
   logic               rd_req_reg, rd_req_next;
   logic [FS_AW-1:0]   rd_addr_reg, rd_addr_next;
   logic               cw_en_reg, cw_en_next;
   logic [CA_W-1:0]    cw_addr_reg, cw_addr_next;
   pix_t               cw_data_reg, cw_data_next;

   clip_t              clip_w;
   logic [TILE_LG:0]   col_ext, row_ext, dec_w_ext, dec_h_ext;
   logic               col_in, row_in, pix_inside, last_pix;
   logic [FS_AW-1:0]   fs_x, fs_y, fs_addr;
   logic [CA_W-1:0]    pix_idx;

   tile_clip u_tile_clip (
      .org_x (org_x_reg),
      .org_y (org_y_reg),
      .clip  (clip_w)
   );

   assign col_ext    = {1'b0, col_reg};
   assign row_ext    = {1'b0, row_reg};
   assign dec_w_ext  = {1'b0, clip_reg.dec_w};
   assign dec_h_ext  = {1'b0, clip_reg.dec_h};
   assign col_in     = (col_ext >= dec_w_ext) && (col_ext < dec_w_ext + clip_reg.w_img);
   assign row_in     = (row_ext >= dec_h_ext) && (row_ext < dec_h_ext + clip_reg.h_img);
   assign pix_inside = clip_reg.in_img && col_in && row_in;
   assign last_pix   = (&row_reg) && (&col_reg);
   assign pix_idx    = {row_reg, col_reg};

   // Frame coordinates never go negative for an inside pixel, so unsigned math is exact.
   assign fs_x    = FS_AW'(clip_reg.x_img) + FS_AW'(col_reg) - FS_AW'(clip_reg.dec_w);
   assign fs_y    = FS_AW'(clip_reg.y_img) + FS_AW'(row_reg) - FS_AW'(clip_reg.dec_h);
   assign fs_addr = FS_AW'(fs_y * FS_AW'(IMG_W)) + fs_x;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         org_x_reg   <= '0;
         org_y_reg   <= '0;
         clip_reg    <= '0;
         row_reg     <= '0;
         col_reg     <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         rd_req_reg  <= 1'b0;
         rd_addr_reg <= '0;
         cw_en_reg   <= 1'b0;
         cw_addr_reg <= '0;
         cw_data_reg <= '0;
      end else begin
         state_reg   <= state_next;
         org_x_reg   <= org_x_next;
         org_y_reg   <= org_y_next;
         clip_reg    <= clip_next;
         row_reg     <= row_next;
         col_reg     <= col_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         rd_req_reg  <= rd_req_next;
         rd_addr_reg <= rd_addr_next;
         cw_en_reg   <= cw_en_next;
         cw_addr_reg <= cw_addr_next;
         cw_data_reg <= cw_data_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      org_x_next   = org_x_reg;
      org_y_next   = org_y_reg;
      clip_next    = clip_reg;
      row_next     = row_reg;
      col_next     = col_reg;
      busy_next    = busy_reg;
      done_next    = 1'b0;
      rd_req_next  = rd_req_reg;
      rd_addr_next = rd_addr_reg;
      cw_en_next   = 1'b0;
      cw_addr_next = cw_addr_reg;
      cw_data_next = cw_data_reg;

      case (state_reg)
         IDLE: begin
            // The cycle showing the done pulse still refuses a new request.
            if (start && !done_reg) begin
               org_x_next = tile_x;
               org_y_next = tile_y;
               busy_next  = 1'b1;
               state_next = CLIP;
            end
         end
         CLIP: begin
            clip_next  = clip_w;
            row_next   = '0;
            col_next   = '0;
            state_next = SCAN;
         end
         SCAN: begin
            if (pix_inside) begin
               rd_req_next  = 1'b1;
               rd_addr_next = fs_addr;
               state_next   = WAIT;
            end else begin
               cw_en_next   = 1'b1;
               cw_addr_next = pix_idx;
               cw_data_next = BG_PIX;
               col_next     = col_reg + 1'b1;
               if (&col_reg) row_next = row_reg + 1'b1;
               state_next   = last_pix ? DONE : SCAN;
            end
         end
         WAIT: begin
            if (rd_ack) begin
               rd_req_next  = 1'b0;
               cw_en_next   = 1'b1;
               cw_addr_next = pix_idx;
               cw_data_next = rd_data;
               col_next     = col_reg + 1'b1;
               if (&col_reg) row_next = row_reg + 1'b1;
               state_next   = last_pix ? DONE : SCAN;
            end
         end
         DONE: begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy    = busy_reg;
   assign done    = done_reg;
   assign rd_req  = rd_req_reg;
   assign rd_addr = rd_addr_reg;
   assign cw_en   = cw_en_reg;
   assign cw_addr = cw_addr_reg;
   assign cw_data = cw_data_reg;

endmodule

// File: tb/tb_cache_tile_fill.sv
// Directed bench for cache_tile_fill: a frame-store responder with programmable ack delay
// and a per-pixel model of the expected raster of cache writes.
module tb_cache_tile_fill;
   import video_in_pkg::*;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic signed [31:0] tile_x, tile_y;
   logic               busy, done, rd_req, rd_ack, cw_en;
   logic [18:0]        rd_addr;
   logic [7:0]         rd_data, cw_data;
   logic [9:0]         cw_addr;

   int checks_cnt = 0;
   int errors_cnt = 0;

   always #5 clk = ~clk;

   cache_tile_fill dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .tile_x  (tile_x),
      .tile_y  (tile_y),
      .busy    (busy),
      .done    (done),
      .rd_req  (rd_req),
      .rd_addr (rd_addr),
      .rd_ack  (rd_ack),
      .rd_data (rd_data),
      .cw_en   (cw_en),
      .cw_addr (cw_addr),
      .cw_data (cw_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] fs_pix(input int addr);
      return 8'((addr * 13 + 7) ^ (addr >> 9));
   endfunction

   // Frame position of tile pixel p for origin (tx,ty).
   function automatic bit pix_model(input int tx, input int ty, input int p, output int addr);
      int gx, gy;
      gx   = tx + (p % 32);
      gy   = ty + (p / 32);
      addr = gy * 640 + gx;
      return (gx >= 0) && (gx < 640) && (gy >= 0) && (gy < 480);
   endfunction

   task automatic run_fill(input int tx, input int ty, input int ack_dly, input bit noise,
                           input bit poke, input int exp_reads, input int exp_done_cyc,
                           input int exp_first, input int exp_last, input string name);
      int   cyc = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0, done_cyc = -1, req_age = 0;
      int   first_addr = -1, last_addr = -1, maddr;
      bit   prev_req = 0, fin = 0, ins;
      logic [18:0] prev_addr = '0;
      @(negedge clk);
      tile_x = tx;
      tile_y = ty;
      start  = 1'b1;
      while (!fin) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (poke && cyc == 40) begin
            start  = 1'b1;
            tile_x = 100;
            tile_y = 100;
         end
         if (cyc == 1) check($sformatf("%s.busy_start", name), busy, 1);
         if (cw_en) begin
            ins = pix_model(tx, ty, wr_cnt, maddr);
            check($sformatf("%s.cw_addr", name), cw_addr, wr_cnt);
            check($sformatf("%s.cw_data@%0d", name, wr_cnt), cw_data, ins ? fs_pix(maddr) : 8'd0);
            wr_cnt++;
         end
         if (rd_req) begin
            if (prev_req) begin
               check($sformatf("%s.rd_addr_hold", name), rd_addr, prev_addr);
            end else begin
               ins = pix_model(tx, ty, wr_cnt, maddr);
               check($sformatf("%s.rd_addr@%0d", name, wr_cnt), rd_addr, maddr);
               rd_cnt++;
               if (first_addr < 0) first_addr = int'(rd_addr);
               last_addr = int'(rd_addr);
            end
         end
         prev_req  = rd_req;
         prev_addr = rd_addr;
         if (done_cyc >= 0) begin
            check($sformatf("%s.done_width", name), done, 0);
            check($sformatf("%s.busy_after", name), busy, 0);
            fin = 1;
         end else if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check($sformatf("%s.busy_at_done", name), busy, 0);
            if (poke) begin
               start  = 1'b1;
               tile_x = 0;
               tile_y = 0;
            end
         end
         if (!fin && cyc > 8000) begin
            check($sformatf("%s.timeout", name), done_cnt, 1);
            fin = 1;
         end
         if (rd_req) begin
            req_age++;
            rd_ack  = (req_age > ack_dly);
            rd_data = fs_pix(int'(rd_addr));
         end else begin
            req_age = 0;
            rd_ack  = noise;
            rd_data = 8'hA5;
         end
      end
      rd_ack = 1'b0;
      check($sformatf("%s.writes", name), wr_cnt, 1024);
      check($sformatf("%s.reads", name), rd_cnt, exp_reads);
      check($sformatf("%s.done_cnt", name), done_cnt, 1);
      if (exp_done_cyc >= 0) check($sformatf("%s.done_cyc", name), done_cyc, exp_done_cyc);
      if (exp_first >= 0) check($sformatf("%s.first_rd", name), first_addr, exp_first);
      if (exp_last >= 0) check($sformatf("%s.last_rd", name), last_addr, exp_last);
      $display("fill %s origin (%0d,%0d): writes %0d reads %0d done at cycle %0d",
               name, tx, ty, wr_cnt, rd_cnt, done_cyc);
   endtask

   initial begin
      int  wr_cnt, req_age;
      bit  hit;
      reset   = 1'b1;
      start   = 1'b0;
      tile_x  = 0;
      tile_y  = 0;
      rd_ack  = 1'b0;
      rd_data = '0;
      repeat (3) @(negedge clk);
      check("rst.busy", busy, 0);
      check("rst.done", done, 0);
      check("rst.rd_req", rd_req, 0);
      check("rst.cw_en", cw_en, 0);
      check("rst.rd_addr", rd_addr, 0);
      check("rst.cw_addr", cw_addr, 0);
      check("rst.cw_data", cw_data, 0);
      reset = 1'b0;

      run_fill(0, 0, 1, 0, 0, 1024, -1, 0, 19871, "t_0_0");
      run_fill(-8, -4, 1, 1, 0, 672, -1, 0, 17303, "t_m8_m4");
      run_fill(624, 464, 1, 0, 0, 256, -1, 297584, 307199, "t_corner");
      run_fill(700, 10, 1, 0, 0, 0, 1027, -1, -1, "t_right_out");
      run_fill(-40, 0, 1, 0, 0, 0, 1027, -1, -1, "t_left_out");
      run_fill(-8, -4, 3, 0, 1, 672, -1, 0, 17303, "t_dly3");

      // Abort a fill while waiting on the read of pixel 100.
      wr_cnt  = 0;
      req_age = 0;
      hit     = 0;
      @(negedge clk);
      tile_x = 0;
      tile_y = 0;
      start  = 1'b1;
      for (int i = 0; i < 3000 && !hit; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (cw_en) wr_cnt++;
         if (rd_req && wr_cnt == 100) begin
            hit = 1;
         end else if (rd_req) begin
            req_age++;
            rd_ack  = (req_age > 3);
            rd_data = fs_pix(int'(rd_addr));
         end else begin
            req_age = 0;
            rd_ack  = 1'b0;
         end
      end
      check("abort.reached_px100", hit, 1);
      reset  = 1'b1;
      rd_ack = 1'b0;
      @(negedge clk);
      check("abort.busy", busy, 0);
      check("abort.done", done, 0);
      check("abort.rd_req", rd_req, 0);
      check("abort.cw_en", cw_en, 0);
      check("abort.rd_addr", rd_addr, 0);
      check("abort.cw_addr", cw_addr, 0);
      check("abort.cw_data", cw_data, 0);
      $display("abort at pixel %0d, outputs cleared", wr_cnt);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("abort.no_done", done, 0);
      end
      run_fill(0, 0, 2, 0, 0, 1024, -1, 0, 19871, "t_after_rst");

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
